// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch I / data D) arbiter for a single-ported memory with fixed read latency.
// Latency: mem_en one cycle after grant, done pulse MEM_LAT+2 cycles after grant; accesses spaced MEM_LAT+3.
// Backpressure: requesters hold req until done; ties alternate round-robin, losers wait in IDLE.
module mem_port_arbiter #(
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_rdata,
    output logic          i_done,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_done,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          gnt_d
);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

    localparam int            CW     = 3;
    localparam logic [CW-1:0] LAT_M1 = CW'(MEM_LAT - 1);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic          grant_go;
    logic          grant_d;

    always_comb begin
        state_nxt = state;
        grant_go  = 1'b0;
        grant_d   = gnt_d;
        case (state)
            IDLE: begin
                if (i_req || d_req) begin
                    grant_go  = 1'b1;
                    // On a tie the requester that did not own the last access wins.
                    grant_d   = (i_req && d_req) ? ~gnt_d : d_req;
                    state_nxt = ACCESS;
                end
            end
            ACCESS:  state_nxt = WAIT;
            WAIT:    if (cnt == '0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            gnt_d     <= 1'b1;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            i_done    <= 1'b0;
            d_done    <= 1'b0;
        end else begin
            state  <= state_nxt;
            mem_en <= 1'b0;
            i_done <= 1'b0;
            d_done <= 1'b0;

            if (grant_go) begin
                gnt_d     <= grant_d;
                mem_en    <= 1'b1;
                mem_addr  <= grant_d ? d_addr : i_addr;
                mem_we    <= grant_d & d_we;
                mem_wdata <= d_wdata;
            end

            if (state == ACCESS) begin
                cnt <= LAT_M1;
            end

            if (state == WAIT) begin
                if (cnt == '0) begin
                    // mem_we still reflects the current access, so it marks a store here.
                    if (gnt_d) begin
                        if (!mem_we) d_rdata <= mem_rdata;
                        d_done <= 1'b1;
                    end else begin
                        i_rdata <= mem_rdata;
                        i_done  <= 1'b1;
                    end
                end else begin
                    cnt <= cnt - 3'd1;
                end
            end
        end
    end

    assign busy = (state != IDLE);

endmodule
